// File: rtl/dp_mem_pkg.sv
// Shared constants, port-op encoding and saturating-counter helper for dp_mem_ctrl.
package dp_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } port_op_e;

  // Increment that sticks at 2**w-1; callers cast the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_v) ? max_v : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/dp_mem_ctrl_if.sv
// Per-port request/data/valid bundle plus collision status for dp_mem_ctrl.
interface dp_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              req_a;
  logic              wren_a;
  logic [ADDR_W-1:0] address_a;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] q_a;
  logic              rvalid_a;

  logic              req_b;
  logic              wren_b;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] q_b;
  logic              rvalid_b;

  logic              collision;
  logic [CNT_W-1:0]  coll_cnt;
  logic              clr_cnt;

  modport master (
    output req_a, wren_a, address_a, data_a,
    output req_b, wren_b, address_b, data_b,
    output clr_cnt,
    input  q_a, rvalid_a, q_b, rvalid_b, collision, coll_cnt
  );

  modport slave (
    input  req_a, wren_a, address_a, data_a,
    input  req_b, wren_b, address_b, data_b,
    input  clr_cnt,
    output q_a, rvalid_a, q_b, rvalid_b, collision, coll_cnt
  );
endinterface

// File: rtl/dp_mem_array.sv
// Bare two-port synchronous RAM, read-first, one registered read per port; 1-cycle latency, no backpressure.
module dp_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we_a,
  input  logic              i_re_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdat_a,
  output logic [DATA_W-1:0] o_rdat_a,
  input  logic              i_we_b,
  input  logic              i_re_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdat_b,
  output logic [DATA_W-1:0] o_rdat_b
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdat_a;
  logic [DATA_W-1:0] r_rdat_b;

  // Port A write is placed last so it would win any overlap that reaches the array.
  always_ff @(posedge i_clk) begin
    if (i_we_b) r_mem[i_addr_b] <= i_wdat_b;
    if (i_we_a) r_mem[i_addr_a] <= i_wdat_a;
    if (i_re_a) r_rdat_a <= r_mem[i_addr_a];
    if (i_re_b) r_rdat_b <= r_mem[i_addr_b];
  end

  assign o_rdat_a = r_rdat_a;
  assign o_rdat_b = r_rdat_b;

endmodule

// File: rtl/dp_mem_ctrl.sv
// Dual-port memory: A-wins write arbitration, saturating collision counter, optional DPMEM_FWD_EN forwarding.
// Read latency OUT_REG+1 cycles; no backpressure, every request is accepted.
module dp_mem_ctrl
  import dp_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OUT_REG = 1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic           i_clock,
  input logic           i_reset_n,
  dp_mem_ctrl_if.slave  bus
);

  port_op_e          w_op_a, w_op_b;
  logic              w_rd_a, w_rd_b, w_wr_a, w_wr_b;
  logic              w_addr_eq, w_coll;
  logic [DATA_W-1:0] w_arr_a, w_arr_b, w_s1_a, w_s1_b;
  logic              r_v1_a, r_v1_b, r_coll;
  logic [CNT_W-1:0]  r_cnt;

  assign w_op_a    = !bus.req_a ? IDLE : (bus.wren_a ? WR : RD);
  assign w_op_b    = !bus.req_b ? IDLE : (bus.wren_b ? WR : RD);
  assign w_rd_a    = (w_op_a == RD);
  assign w_rd_b    = (w_op_b == RD);
  assign w_wr_a    = (w_op_a == WR);
  assign w_wr_b    = (w_op_b == WR);
  assign w_addr_eq = (bus.address_a == bus.address_b);
  assign w_coll    = w_wr_a & w_wr_b & w_addr_eq;

  dp_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .i_clk    (i_clock),
    .i_we_a   (w_wr_a),
    .i_re_a   (w_rd_a),
    .i_addr_a (bus.address_a),
    .i_wdat_a (bus.data_a),
    .o_rdat_a (w_arr_a),
    .i_we_b   (w_wr_b & ~w_coll),
    .i_re_b   (w_rd_b),
    .i_addr_b (bus.address_b),
    .i_wdat_b (bus.data_b),
    .o_rdat_b (w_arr_b)
  );

`ifdef DPMEM_FWD_EN
  logic              r_fwd_a, r_fwd_b;
  logic [DATA_W-1:0] r_fwd_dat_a, r_fwd_dat_b;

  // A reader never writes in the same cycle, so only the other port's write data can be forwarded.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fwd_a     <= 1'b0;
      r_fwd_b     <= 1'b0;
      r_fwd_dat_a <= '0;
      r_fwd_dat_b <= '0;
    end else begin
      r_fwd_a     <= w_rd_a & w_wr_b & w_addr_eq;
      r_fwd_b     <= w_rd_b & w_wr_a & w_addr_eq;
      r_fwd_dat_a <= bus.data_b;
      r_fwd_dat_b <= bus.data_a;
    end
  end

  assign w_s1_a = r_fwd_a ? r_fwd_dat_a : w_arr_a;
  assign w_s1_b = r_fwd_b ? r_fwd_dat_b : w_arr_b;
`else
  assign w_s1_a = w_arr_a;
  assign w_s1_b = w_arr_b;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_v1_a <= 1'b0;
      r_v1_b <= 1'b0;
      r_coll <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_v1_a <= w_rd_a;
      r_v1_b <= w_rd_b;
      r_coll <= w_coll;
      if (bus.clr_cnt)
        r_cnt <= '0;
      else if (w_coll)
        r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
    end
  end

  assign bus.collision = r_coll;
  assign bus.coll_cnt  = r_cnt;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_v2_a, r_v2_b;
      logic [DATA_W-1:0] r_q_a, r_q_b;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_v2_a <= 1'b0;
          r_v2_b <= 1'b0;
          r_q_a  <= '0;
          r_q_b  <= '0;
        end else begin
          r_v2_a <= r_v1_a;
          r_v2_b <= r_v1_b;
          if (r_v1_a) r_q_a <= w_s1_a;
          if (r_v1_b) r_q_b <= w_s1_b;
        end
      end

      assign bus.q_a      = r_q_a;
      assign bus.q_b      = r_q_b;
      assign bus.rvalid_a = r_v2_a;
      assign bus.rvalid_b = r_v2_b;
    end else begin : g_noreg
      // The array register is not reset, so a separate holding copy keeps q at 0 after reset.
      logic [DATA_W-1:0] r_hold_a, r_hold_b;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_hold_a <= '0;
          r_hold_b <= '0;
        end else begin
          if (r_v1_a) r_hold_a <= w_s1_a;
          if (r_v1_b) r_hold_b <= w_s1_b;
        end
      end

      assign bus.q_a      = r_v1_a ? w_s1_a : r_hold_a;
      assign bus.q_b      = r_v1_b ? w_s1_b : r_hold_b;
      assign bus.rvalid_a = r_v1_a;
      assign bus.rvalid_b = r_v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Scoreboard bench for dp_mem_ctrl: reference memory model predicts read data, latency, collisions and count.
module tb_dp_mem_ctrl;

  localparam int DW      = 16;
  localparam int AW      = 10;
  localparam int CW      = 8;
  localparam int OUT_REG = 1;
  localparam int LAT     = OUT_REG + 1;

  typedef struct {
    logic [DW-1:0] dat;
    int            due;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  sb_t           qa[$];
  sb_t           qb[$];
  int            qc[$];
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  logic [CW-1:0] mdl_cnt = '0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  sb_t           ea, eb;

  dp_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  dp_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(OUT_REG), .CNT_W(CW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every rvalid/collision must match a scoreboard entry at its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (qa.size() > 0 && qa[0].due < cyc) begin
        void'(qa.pop_front());
        chk("rvalid_a_missing", 32'd0, 32'd1);
      end
      while (qb.size() > 0 && qb[0].due < cyc) begin
        void'(qb.pop_front());
        chk("rvalid_b_missing", 32'd0, 32'd1);
      end
      while (qc.size() > 0 && qc[0] < cyc) begin
        void'(qc.pop_front());
        chk("collision_missing", 32'd0, 32'd1);
      end
      if (bus.rvalid_a) begin
        if (qa.size() == 0) chk("rvalid_a_unexpected", 32'd1, 32'd0);
        else begin
          ea = qa.pop_front();
          chk("q_a", 32'(bus.q_a), 32'(ea.dat));
          chk("lat_a", 32'(cyc), 32'(ea.due));
          last_a = ea.dat;
        end
      end else chk("hold_a", 32'(bus.q_a), 32'(last_a));
      if (bus.rvalid_b) begin
        if (qb.size() == 0) chk("rvalid_b_unexpected", 32'd1, 32'd0);
        else begin
          eb = qb.pop_front();
          chk("q_b", 32'(bus.q_b), 32'(eb.dat));
          chk("lat_b", 32'(cyc), 32'(eb.due));
          last_b = eb.dat;
        end
      end else chk("hold_b", 32'(bus.q_b), 32'(last_b));
      if (bus.collision) begin
        if (qc.size() == 0) chk("collision_unexpected", 32'd1, 32'd0);
        else chk("collision_cyc", 32'(cyc), 32'(qc.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic clr);
    sb_t  e;
    logic coll;
    bus.req_a = ra; bus.wren_a = wa; bus.address_a = aa; bus.data_a = da;
    bus.req_b = rb; bus.wren_b = wb; bus.address_b = ab; bus.data_b = db;
    bus.clr_cnt = clr;
    coll = ra && wa && rb && wb && (aa == ab);
    if (ra && !wa) begin
      e.dat = mdl[aa];
`ifdef DPMEM_FWD_EN
      if (rb && wb && ab == aa) e.dat = db;
`endif
      e.due = cyc + LAT;
      qa.push_back(e);
    end
    if (rb && !wb) begin
      e.dat = mdl[ab];
`ifdef DPMEM_FWD_EN
      if (ra && wa && aa == ab) e.dat = da;
`endif
      e.due = cyc + LAT;
      qb.push_back(e);
    end
    if (coll) qc.push_back(cyc + 1);
    if (clr) mdl_cnt = '0;
    else if (coll && mdl_cnt != {CW{1'b1}}) mdl_cnt = mdl_cnt + 1'b1;
    if (rb && wb && !coll) mdl[ab] = db;
    if (ra && wa) mdl[aa] = da;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
    bus.req_a = 1'b0; bus.wren_a = 1'b0; bus.address_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.wren_b = 1'b0; bus.address_b = '0; bus.data_b = '0;
    bus.clr_cnt = 1'b0;
    #1;
    chk("rst_q_a", 32'(bus.q_a), 32'd0);
    chk("rst_q_b", 32'(bus.q_b), 32'd0);
    chk("rst_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'd0);
    chk("rst_collision", 32'(bus.collision), 32'd0);
    chk("rst_coll_cnt", 32'(bus.coll_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Seed boundary and directed addresses.
    drive(1'b1, 1'b1, 10'd0, 16'hC0DE, 1'b1, 1'b1, 10'd1023, 16'hBEEF, 1'b0);
    drive(1'b1, 1'b1, 10'd3, 16'h0001, 1'b0, 1'b0, '0, '0, 1'b0);

    // Write on A, read back on B.
    drive(1'b1, 1'b1, 10'd5, 16'h1234, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0, 1'b0);
    idle(3);

    // Same-address write collision: A must win.
    drive(1'b1, 1'b1, 10'd9, 16'hAAAA, 1'b1, 1'b1, 10'd9, 16'h5555, 1'b0);
    chk("coll_cnt_one", 32'(bus.coll_cnt), 32'd1);
    drive(1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b0, 10'd9, '0, 1'b0);
    idle(3);

    // Read while the other port writes the same address.
    drive(1'b1, 1'b1, 10'd3, 16'h00FF, 1'b1, 1'b0, 10'd3, '0, 1'b0);
    drive(1'b1, 1'b0, 10'd3, '0, 1'b1, 1'b1, 10'd3, 16'h0077, 1'b0);
    drive(1'b1, 1'b0, 10'd3, '0, 1'b1, 1'b0, 10'd3, '0, 1'b0);
    idle(3);

    // Back-to-back boundary reads on both ports.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, (i % 2 == 0) ? 10'd0 : 10'd1023, '0,
            1'b1, 1'b0, (i % 2 == 0) ? 10'd1023 : 10'd0, '0, 1'b0);
    idle(3);

    // Counter saturation and clear priority.
    for (int i = 0; i < 300; i++)
      drive(1'b1, 1'b1, 10'd20, 16'(i), 1'b1, 1'b1, 10'd20, 16'(~i), 1'b0);
    chk("coll_cnt_sat", 32'(bus.coll_cnt), 32'd255);
    chk("coll_cnt_model", 32'(bus.coll_cnt), 32'(mdl_cnt));
    drive(1'b1, 1'b1, 10'd20, 16'h0101, 1'b1, 1'b1, 10'd20, 16'h0202, 1'b0);
    chk("coll_cnt_stays", 32'(bus.coll_cnt), 32'd255);
    drive(1'b1, 1'b1, 10'd20, 16'h0303, 1'b1, 1'b1, 10'd20, 16'h0404, 1'b1);
    chk("coll_cnt_clr_wins", 32'(bus.coll_cnt), 32'd0);
    drive(1'b1, 1'b1, 10'd21, 16'h0505, 1'b1, 1'b1, 10'd21, 16'h0606, 1'b0);
    chk("coll_cnt_after_clr", 32'(bus.coll_cnt), 32'd1);
    drive(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd21, '0, 1'b0);
    idle(3);

    // Random traffic over a small, fully initialised address window.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 10'(i), 16'(i * 16'h1111), 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 15) == 0));
    chk("coll_cnt_random", 32'(bus.coll_cnt), 32'(mdl_cnt));
    idle(3);

    // Reset in the middle of a read stream.
    drive(1'b1, 1'b0, 10'd1023, '0, 1'b1, 1'b0, 10'd9, '0, 1'b0);
    drive(1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b0, 10'd1023, '0, 1'b0);
    drive(1'b1, 1'b0, 10'd1023, '0, 1'b1, 1'b0, 10'd9, '0, 1'b0);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_q_a", 32'(bus.q_a), 32'd0);
    chk("midrst_q_b", 32'(bus.q_b), 32'd0);
    chk("midrst_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'd0);
    chk("midrst_collision", 32'(bus.collision), 32'd0);
    chk("midrst_coll_cnt", 32'(bus.coll_cnt), 32'd0);
    qa.delete();
    qb.delete();
    qc.delete();
    last_a = '0;
    last_b = '0;
    mdl_cnt = '0;
    step();
    step();
    rst_n = 1'b1;
    idle(5);

    // Post-reset sanity read.
    drive(1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd0, '0, 1'b0);
    for (int i = 0; i < 10 && (qa.size() + qb.size() + qc.size()) > 0; i++) idle(1);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    chk("drain_coll", 32'(qc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
